// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: load-sequence states and
// stream-format constants.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_e;

    localparam int         LEN_BYTES  = 2;
    localparam int         WORD_BYTES = 4;
    localparam logic [7:0] CSUM_INIT  = 8'h00;

    // Running checksum over instruction bytes
    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/inst_loader.sv
// Boot loader: parses a length-prefixed byte stream into 32-bit instruction
// words, writes them to instruction memory and releases the CPU reset on a good checksum.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_cnt
);

    localparam int               LEN_W     = LEN_BYTES * 8;
    localparam logic [LEN_W:0]   DEPTH     = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;
    localparam logic [1:0]       LAST_BYTE = 2'(WORD_BYTES - 1);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [31:0]         shift_q, shift_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [7:0]          csum_q, csum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [15:0]         wcnt_q, wcnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                ready_s;
    logic                accept_s;

    // Ready depends on rst_n directly so it is low while reset is held
    assign ready_s  = rst_n && (state_q == LEN_LO || state_q == LEN_HI ||
                                state_q == DATA   || state_q == CSUM);
    assign accept_s = in_valid && ready_s;

    // Next-state and output computation; restart overrides any byte acceptance
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        shift_d     = shift_q;
        bcnt_d      = bcnt_q;
        csum_d      = csum_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wcnt_d      = wcnt_q;
        done_d      = done_q;
        err_d       = err_q;
        cpu_rst_n_d = cpu_rst_n_q;
        if (restart) begin
            state_d     = LEN_LO;
            len_d       = {LEN_W{1'b0}};
            shift_d     = 32'h0000_0000;
            bcnt_d      = 2'd0;
            csum_d      = CSUM_INIT;
            wcnt_d      = 16'd0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            cpu_rst_n_d = 1'b0;
        end else begin
            case (state_q)
                LEN_LO: begin
                    if (accept_s) begin
                        len_d   = {len_q[LEN_W-1:8], in_data};
                        state_d = LEN_HI;
                    end else begin
                        state_d = LEN_LO;
                    end
                end
                LEN_HI: begin
                    if (accept_s) begin
                        len_d = {in_data, len_q[7:0]};
                        if ({1'b0, len_d} > DEPTH) begin
                            state_d = ERR;
                        end else if (len_d == {LEN_W{1'b0}}) begin
                            state_d = CSUM;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = LEN_HI;
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        // First byte of a word ends up in bits 7:0 after four shifts
                        shift_d = {in_data, shift_q[31:8]};
                        csum_d  = csum_next(csum_q, in_data);
                        bcnt_d  = bcnt_q + 2'd1;
                        if (bcnt_q == LAST_BYTE) begin
                            we_d    = 1'b1;
                            addr_d  = wcnt_q[ADDR_W-1:0];
                            wdata_d = shift_d;
                            wcnt_d  = wcnt_q + 16'd1;
                            if (wcnt_d == len_q) begin
                                state_d = CSUM;
                            end else begin
                                state_d = DATA;
                            end
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
                CSUM: begin
                    if (accept_s) begin
                        state_d = (in_data == csum_q) ? DONE : ERR;
                    end else begin
                        state_d = CSUM;
                    end
                end
                DONE: begin
                    done_d      = 1'b1;
                    cpu_rst_n_d = 1'b1;
                end
                ERR: begin
                    err_d       = 1'b1;
                    cpu_rst_n_d = 1'b0;
                end
                default: begin
                    state_d = ERR;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LEN_LO;
            len_q       <= {LEN_W{1'b0}};
            shift_q     <= 32'h0000_0000;
            bcnt_q      <= 2'd0;
            csum_q      <= CSUM_INIT;
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= 32'h0000_0000;
            wcnt_q      <= 16'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            bcnt_q      <= bcnt_d;
            csum_q      <= csum_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wcnt_q      <= wcnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign in_ready   = ready_s;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_cnt   = wcnt_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed and randomized load streams
// compared against a stream-level reference model.
module tb_inst_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst_n;
    logic              restart;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic              err;
    logic [15:0]       word_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    logic [15:0]       wr_cnt[$];

    always #5 clk = ~clk;

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cnt.push_back(word_cnt);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t make_stream(input int n, input bit bad);
        bq_t        s;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            s.push_back(b);
            x = x ^ b;
        end
        s.push_back(bad ? (x ^ 8'($urandom_range(255, 1))) : x);
        return s;
    endfunction

    // Reference: what a complete stream should produce
    task automatic model(input bq_t s, output bq_t dummy, output logic [31:0] ew[$],
                         output logic e_done, output logic e_err);
        int         n;
        logic [7:0] x;
        dummy = s;
        ew.delete();
        n = int'(s[0]) + 256 * int'(s[1]);
        e_done = 1'b0;
        e_err  = 1'b1;
        if (n <= DEPTH) begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                ew.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
                x = x ^ s[2+4*i] ^ s[2+4*i+1] ^ s[2+4*i+2] ^ s[2+4*i+3];
            end
            e_done = (s[2 + 4 * n] == x);
            e_err  = !e_done;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        repeat ($urandom_range(maxgap, 0)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t s, input int maxgap);
        foreach (s[i]) send_byte(s[i], maxgap);
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
        wr_cnt.delete();
    endtask

    task automatic check_load(input string tag, input bq_t s);
        logic [31:0] ew[$];
        logic        e_done;
        logic        e_err;
        bq_t         d;
        model(s, d, ew, e_done, e_err);
        repeat (4) @(negedge clk);
        check({tag, ".nwr"}, 32'(wr_data.size()), 32'(ew.size()));
        foreach (ew[i]) begin
            if (i < wr_data.size()) begin
                check($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
                check($sformatf("%s.data%0d", tag, i), wr_data[i], ew[i]);
                check($sformatf("%s.cnt%0d", tag, i), 32'(wr_cnt[i]), 32'(i + 1));
            end
        end
        check({tag, ".word_cnt"}, 32'(word_cnt), 32'(ew.size()));
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".err"}, 32'(err), 32'(e_err));
        check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(e_done));
        check({tag, ".in_ready"}, 32'(in_ready), 32'h0);
    endtask

    task automatic do_restart(input string tag, input bit with_byte);
        restart  = 1'b1;
        in_valid = with_byte;
        in_data  = 8'h05;
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        check({tag, ".rs_done"}, 32'(done), 32'h0);
        check({tag, ".rs_err"}, 32'(err), 32'h0);
        check({tag, ".rs_cpu"}, 32'(cpu_rst_n), 32'h0);
        check({tag, ".rs_wcnt"}, 32'(word_cnt), 32'h0);
        check({tag, ".rs_ready"}, 32'(in_ready), 32'h1);
        @(negedge clk);
        clear_writes();
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 32'h0);
        check({tag, ".we"}, 32'(imem_we), 32'h0);
        check({tag, ".addr"}, 32'(imem_addr), 32'h0);
        check({tag, ".wdata"}, imem_wdata, 32'h0);
        check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'h0);
        check({tag, ".done"}, 32'(done), 32'h0);
        check({tag, ".err"}, 32'(err), 32'h0);
        check({tag, ".word_cnt"}, 32'(word_cnt), 32'h0);
    endtask

    initial begin
        bq_t s;
        bq_t s2;
        rst_n    = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.ready_after", 32'(in_ready), 32'h1);

        // Known-good single-word load
        s = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h02, 8'h8B, 8'hA9};
        send_stream(s, 0);
        check_load("n1_good", s);
        check("n1_good.word", (wr_data.size() > 0) ? wr_data[0] : 32'hDEAD_BEEF, 32'h8B02_0020);
        do_restart("r1", 1'b0);

        // Same stream with wrong checksum
        s = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h02, 8'h8B, 8'hA8};
        send_stream(s, 0);
        check_load("n1_bad", s);
        do_restart("r2", 1'b0);

        // Length one beyond the memory depth
        s = '{8'h01, 8'h01};
        send_stream(s, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        check_load("n257", s);
        do_restart("r3", 1'b0);

        // Three words with a bursty valid
        s = make_stream(3, 1'b0);
        send_stream(s, 3);
        check_load("n3_gaps", s);
        do_restart("r4", 1'b0);

        // Full-depth load, back to back
        s = make_stream(DEPTH, 1'b0);
        send_stream(s, 0);
        check_load("n256", s);
        do_restart("r5", 1'b0);

        for (int k = 0; k < 4; k++) begin
            s = make_stream(int'($urandom_range(6, 1)), bit'($urandom_range(1, 0)));
            send_stream(s, int'($urandom_range(2, 0)));
            check_load($sformatf("rand%0d", k), s);
            do_restart($sformatf("rr%0d", k), 1'b0);
        end

        // Abort a two-word load after five data bytes
        s = make_stream(2, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(s[i], 0);
        @(negedge clk);
        check("abort.nwr", 32'(wr_data.size()), 32'h1);
        check("abort.word0", (wr_data.size() > 0) ? wr_data[0] : 32'hDEAD_BEEF,
              {s[5], s[4], s[3], s[2]});
        do_restart("abort", 1'b0);
        do_restart("abort_byte", 1'b1);
        s2 = make_stream(1, 1'b0);
        send_stream(s2, 0);
        check_load("after_abort", s2);
        do_restart("r6", 1'b0);

        // Reset in the middle of a four-word load
        s = make_stream(4, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(s[i], 0);
        @(negedge clk);
        check("midrst.nwr", 32'(wr_data.size()), 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        rst_n = 1'b1;
        clear_writes();
        @(negedge clk);
        check("midrst.ready_after", 32'(in_ready), 32'h1);
        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s, 0);
        check_load("n0", s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
